// File: rtl/decode_onehot_pkg.sv
// decode_pkg: shared constants and types for the registered one-hot decoder
// and the pulse-shaping helpers of the time-tagging path.
package decode_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int CNT_W       = 8;
    localparam int STRETCH_MIN = 0;
    localparam int STRETCH_MAX = 255;
    localparam int SEL_W_MIN   = 1;
    localparam int SEL_W_MAX   = 5;

    // True when more than one bit of a (zero-extended) vector is set.
    function automatic logic is_multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/decode_onehot_stretch_counter.sv
// stretch_counter: loadable down-counter with a terminal-count flag.
// The flag is high while the count sits at 1, so the owner can end a pulse on
// the next edge; the count never wraps below zero.
module stretch_counter
    import decode_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire
);

    logic [W-1:0] r_value;

    // Load takes priority over decrement; decrement stops at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec && (r_value != '0)) begin
            r_value <= r_value - W'(1);
        end
    end

    assign o_expire = (r_value == W'(1));

endmodule

// File: rtl/decode_onehot.sv
// decode_onehot: registered SEL_W-to-2^SEL_W one-hot decoder with select
// qualifier, pulse stretch (STRETCH>0) or level hold (STRETCH=0), retrigger
// handling and a sticky collision flag.
// Optional integrity guard enabled by defining DECODE_ONEHOT_CHECK_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | regout all zero, busy low, waiting for sel_valid
// ST_ACTIVE | regout one-hot, busy high, pulse running or level held
module decode_onehot
    import decode_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int STRETCH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_sel_valid,
    input  logic                  i_clear,
    output logic [(2**SEL_W)-1:0] o_regout,
    output logic                  o_busy,
    output logic                  o_collide,
    output logic                  o_onehot_err
);

    localparam int NOUT = 2**SEL_W;
    localparam logic [NOUT-1:0] ONE = NOUT'(1);
    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH);
    localparam bit PULSE_MODE = (STRETCH != 0);

    state_t          r_state;
    logic [NOUT-1:0] r_regout;
    logic            r_busy;
    logic            r_collide;

    logic [NOUT-1:0] w_code;
    logic            w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic            w_cnt_dec;
    logic            w_expire;

    assign w_code = ONE << i_sel;

    // Clear forces the counter to zero; every accepted select reloads it.
    assign w_cnt_load     = i_clear || i_sel_valid;
    assign w_cnt_load_val = i_clear ? '0 : STRETCH_LD;
    assign w_cnt_dec      = PULSE_MODE && (r_state == ST_ACTIVE) && !i_sel_valid;

    stretch_counter #(
        .W (CNT_W)
    ) u_stretch_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_expire   (w_expire)
    );

    // Decoder FSM; all outputs registered, clear outranks a same-cycle select.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_state   <= ST_IDLE;
            r_regout  <= '0;
            r_busy    <= 1'b0;
            r_collide <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_sel_valid) begin
                        r_regout <= w_code;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (i_sel_valid) begin
                        if (w_code != r_regout) begin
                            r_collide <= 1'b1;
                        end
                        r_regout <= w_code;
                    end else if (PULSE_MODE && w_expire) begin
                        r_regout <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_regout <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODE_ONEHOT_CHECK_EN
    logic r_onehot_err;

    // Sticky upset guard: only reset clears it, so a soft clear cannot hide an SEU.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_onehot_err <= 1'b0;
        end else if (is_multi_hot(32'(r_regout))) begin
            r_onehot_err <= 1'b1;
        end
    end

    assign o_onehot_err = r_onehot_err;
`else
    assign o_onehot_err = 1'b0;
`endif

    assign o_regout  = r_regout;
    assign o_busy    = r_busy;
    assign o_collide = r_collide;

endmodule

// File: tb/tb_decode_onehot.sv
// tb_decode_onehot: four decoder configurations driven by shared stimulus and
// compared every cycle against a remaining-cycles reference model.
module tb_decode_onehot;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel_valid;
    logic       clear;
    logic [2:0] sel;

    logic [3:0] reg_a, reg_c, reg_d;
    logic [7:0] reg_b;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       col_a, col_b, col_c, col_d;
    logic       err_a, err_b, err_c, err_d;

    int total = 0;
    int bad   = 0;

    int sw [4] = '{2, 3, 2, 2};
    int st [4] = '{1, 4, 0, 10};

    logic [31:0] exp_reg [4];
    int          remain  [4];
    logic        exp_col [4];
    logic        exp_err [4];

    logic [31:0] obs_reg  [4];
    logic        obs_busy [4];
    logic        obs_col  [4];
    logic        obs_err  [4];

    always #5 clk = ~clk;

    decode_onehot #(.SEL_W(2), .STRETCH(1)) u_a (
        .i_clk(clk), .i_reset(reset), .i_sel(sel[1:0]), .i_sel_valid(sel_valid),
        .i_clear(clear), .o_regout(reg_a), .o_busy(busy_a), .o_collide(col_a),
        .o_onehot_err(err_a));
    decode_onehot #(.SEL_W(3), .STRETCH(4)) u_b (
        .i_clk(clk), .i_reset(reset), .i_sel(sel), .i_sel_valid(sel_valid),
        .i_clear(clear), .o_regout(reg_b), .o_busy(busy_b), .o_collide(col_b),
        .o_onehot_err(err_b));
    decode_onehot #(.SEL_W(2), .STRETCH(0)) u_c (
        .i_clk(clk), .i_reset(reset), .i_sel(sel[1:0]), .i_sel_valid(sel_valid),
        .i_clear(clear), .o_regout(reg_c), .o_busy(busy_c), .o_collide(col_c),
        .o_onehot_err(err_c));
    decode_onehot #(.SEL_W(2), .STRETCH(10)) u_d (
        .i_clk(clk), .i_reset(reset), .i_sel(sel[1:0]), .i_sel_valid(sel_valid),
        .i_clear(clear), .o_regout(reg_d), .o_busy(busy_d), .o_collide(col_d),
        .o_onehot_err(err_d));

    always_comb begin
        obs_reg[0] = 32'(reg_a); obs_busy[0] = busy_a; obs_col[0] = col_a; obs_err[0] = err_a;
        obs_reg[1] = 32'(reg_b); obs_busy[1] = busy_b; obs_col[1] = col_b; obs_err[1] = err_b;
        obs_reg[2] = 32'(reg_c); obs_busy[2] = busy_c; obs_col[2] = col_c; obs_err[2] = err_c;
        obs_reg[3] = 32'(reg_d); obs_busy[3] = busy_d; obs_col[3] = col_d; obs_err[3] = err_d;
    end

    // Reference: output is the decoded code for "remain" more cycles (forever at STRETCH=0).
    task automatic model_step();
        logic [31:0] code;
        for (int i = 0; i < 4; i++) begin
            code = 32'd1 << (32'(sel) & ((32'd1 << sw[i]) - 32'd1));
            if (reset || clear) begin
                exp_reg[i] = 32'd0;
                remain[i]  = 0;
                exp_col[i] = 1'b0;
                if (reset) exp_err[i] = 1'b0;
            end else if (sel_valid) begin
                if (exp_reg[i] != 32'd0 && exp_reg[i] != code) exp_col[i] = 1'b1;
                exp_reg[i] = code;
                remain[i]  = st[i];
            end else if (exp_reg[i] != 32'd0 && st[i] > 0) begin
                remain[i] = remain[i] - 1;
                if (remain[i] == 0) exp_reg[i] = 32'd0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            total++;
            assert (obs_reg[i] === exp_reg[i]) else begin
                bad++;
                $error("FAIL %s inst%0d regout got=%h exp=%h", tag, i, obs_reg[i], exp_reg[i]);
            end
            total++;
            assert (obs_busy[i] === (exp_reg[i] != 32'd0)) else begin
                bad++;
                $error("FAIL %s inst%0d busy got=%b exp=%b", tag, i, obs_busy[i], exp_reg[i] != 32'd0);
            end
            total++;
            assert (obs_col[i] === exp_col[i]) else begin
                bad++;
                $error("FAIL %s inst%0d collide got=%b exp=%b", tag, i, obs_col[i], exp_col[i]);
            end
            total++;
            assert (obs_err[i] === exp_err[i]) else begin
                bad++;
                $error("FAIL %s inst%0d onehot_err got=%b exp=%b", tag, i, obs_err[i], exp_err[i]);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] s, input logic c, input logic r,
                        input string tag);
        @(negedge clk);
        sel_valid = v;
        sel       = s;
        clear     = c;
        reset     = r;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1; sel_valid = 1'b0; clear = 1'b0; sel = 3'd0;
        for (int i = 0; i < 4; i++) begin
            exp_reg[i] = 32'd0; remain[i] = 0; exp_col[i] = 1'b0; exp_err[i] = 1'b0;
        end

        // Reset state
        step(1'b0, 3'd0, 1'b0, 1'b1, "reset");
        step(1'b0, 3'd0, 1'b0, 1'b1, "reset");
        chk("reset_reg_b", 32'(reg_b), 32'h0);
        chk("reset_busy_b", 32'(busy_b), 32'h0);
        idle(2, "post_reset");

        // STRETCH=1 single-cycle pulse
        step(1'b1, 3'd2, 1'b0, 1'b0, "t1_accept");
        chk("t1_hi", 32'(reg_a), 32'h4);
        chk("t1_busy_hi", 32'(busy_a), 32'h1);
        idle(1, "t1_after");
        chk("t1_lo", 32'(reg_a), 32'h0);
        chk("t1_busy_lo", 32'(busy_a), 32'h0);
        idle(8, "t1_drain");
        step(1'b0, 3'd0, 1'b1, 1'b0, "t1_clear");

        // STRETCH=4 with same-code retrigger
        step(1'b1, 3'd5, 1'b0, 1'b0, "t2_accept");
        chk("t2_hi", 32'(reg_b), 32'h20);
        idle(1, "t2_wait");
        step(1'b1, 3'd5, 1'b0, 1'b0, "t2_retrig");
        idle(3, "t2_hold");
        chk("t2_still_hi", 32'(reg_b), 32'h20);
        idle(1, "t2_end");
        chk("t2_lo", 32'(reg_b), 32'h0);
        chk("t2_no_collide", 32'(col_b), 32'h0);
        idle(8, "t2_drain");

        // Different-code retrigger raises sticky collide
        step(1'b0, 3'd0, 1'b1, 1'b0, "t3_clear0");
        step(1'b1, 3'd1, 1'b0, 1'b0, "t3_first");
        chk("t3_first_code", 32'(reg_b), 32'h02);
        idle(1, "t3_gap");
        step(1'b1, 3'd3, 1'b0, 1'b0, "t3_second");
        chk("t3_second_code", 32'(reg_b), 32'h08);
        chk("t3_collide", 32'(col_b), 32'h1);
        idle(10, "t3_sticky");
        chk("t3_collide_held", 32'(col_b), 32'h1);
        step(1'b0, 3'd0, 1'b1, 1'b0, "t3_clear");
        chk("t3_collide_cleared", 32'(col_b), 32'h0);

        // Level mode hold, then clear beating a same-cycle select
        step(1'b1, 3'd0, 1'b0, 1'b0, "t4_accept");
        idle(100, "t4_hold");
        chk("t4_level_held", 32'(reg_c), 32'h1);
        step(1'b1, 3'd3, 1'b1, 1'b0, "t4_clear_vs_sel");
        chk("t4_cleared", 32'(reg_c), 32'h0);
        idle(2, "t4_idle");
        chk("t4_stays_idle", 32'(reg_c), 32'h0);

        // Reset mid-pulse (STRETCH=10)
        step(1'b1, 3'd2, 1'b0, 1'b0, "t5_accept");
        idle(4, "t5_run");
        chk("t5_mid", 32'(reg_d), 32'h4);
        step(1'b0, 3'd0, 1'b0, 1'b1, "t5_reset");
        chk("t5_reg_zero", 32'(reg_d), 32'h0);
        chk("t5_busy_zero", 32'(busy_d), 32'h0);
        idle(12, "t5_no_resume");
        chk("t5_still_zero", 32'(reg_d), 32'h0);

        // Randomised traffic
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0), "random");
        end

`ifdef DECODE_ONEHOT_CHECK_EN
        // Inject a two-hot upset into the level-mode instance
        step(1'b0, 3'd0, 1'b0, 1'b1, "t6_reset");
        @(negedge clk);
        sel_valid = 1'b0; clear = 1'b0; reset = 1'b0;
        force u_c.r_regout = 4'h6;
        @(posedge clk);
        #1;
        release u_c.r_regout;
        chk("t6_err_set", 32'(err_c), 32'h1);
        exp_err[2] = 1'b1;
        step(1'b0, 3'd0, 1'b1, 1'b0, "t6_clear");
        chk("t6_err_survives_clear", 32'(err_c), 32'h1);
        step(1'b0, 3'd0, 1'b0, 1'b1, "t6_reset2");
        chk("t6_err_reset", 32'(err_c), 32'h0);
`else
        chk("t6_err_tied_low", 32'(err_c), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
